barcodescanner_timer_sequencer: RTL
===================================

Name: barcodescanner_timer_sequencer

Overview:
- Avalon-MM master FSM that programs and services the 16-bit-data interval timer over its register slave port. No CPU involvement.
- Loads the period, starts the timer, clears timeouts on irq, counts ticks, and on request captures a counter snapshot.
- Sits beside the Nios timer in the barcode scanner subsystem and provides hardware-timed scan ticks.
- Timer register map: 0 status (write clears timeout; read {run,to}), 1 control {stop,start,cont,ito}, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h. A write to 4 or 5 latches the snapshot.

Parameters:
- TICK_W, 16, width of tick_count.
- SNAP_ENABLE, 1, 0 = ignore snap_req; the snapshot states are never entered.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle start pulse.
- stop  in  1  one-cycle stop pulse.
- continuous  in  1  selects continuous mode; sampled at start.
- period  in  32  timer period; sampled at start.
- snap_req  in  1  one-cycle snapshot request.
- timer_irq  in  1  irq from the timer.
- avm_address  out  3  timer register address.
- avm_chipselect  out  1  bus select.
- avm_write_n  out  1  active-low write.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  read data; registered in the slave, valid the cycle after the address is presented.
- busy  out  1  high in every state except IDLE.
- tick_pulse  out  1  one-cycle pulse per serviced timeout.
- tick_count  out  TICK_W  count of serviced timeouts; wraps.
- snapshot  out  32  last captured counter value.
- snapshot_valid  out  1  one-cycle pulse when snapshot updates.

Behaviour:
- Reset values: all outputs 0 except avm_write_n=1. FSM goes to IDLE. Latched period, mode and snap_pend are cleared.
- Bus rules: every non-IDLE state drives exactly one single-cycle access. A state drives chipselect=1 and write_n=0 for a write, or write_n=1 for a read. IDLE and RUN drive chipselect=0, address 0, writedata 0. No waitrequest; every access completes in one cycle.
- IDLE: on start, latch period/continuous, zero tick_count, go to WR_STOP. Start while busy is ignored.
- WR_STOP: write addr1 = 0x0008, then WR_PL.
- WR_PL: write addr2 = period[15:0], then WR_PH.
- WR_PH: write addr3 = period[31:16], then WR_CTRL.
- WR_CTRL: write addr1 = {stop=0, start=1, cont, ito=1}, i.e. 0x0007 when cont=1 and 0x0005 when cont=0. Then RUN.
- RUN: priority is timer_irq > stop > snap_pend.
  - timer_irq goes to WR_STATUS.
  - stop goes to HALT.
  - snap_pend (with SNAP_ENABLE) goes to WR_SNAP.
- WR_STATUS: write addr0 = 0x0000. In the same cycle assert tick_pulse and increment tick_count (wraps from all-ones to 0). Next state is RUN if cont=1, else IDLE.
  - timer_irq deasserts one cycle after this write; RUN must not re-service it. WR_STATUS always returns through RUN, whose irq check is one cycle later.
- HALT: write addr1 = 0x0008, then IDLE. tick_count is held.
- snap_req pulse:
  - Sets snap_pend in any non-IDLE state; cleared on entering WR_SNAP.
  - Ignored in IDLE.
  - Multiple pulses before service collapse to one.
- Snapshot sequence:
  - WR_SNAP: write addr4 = 0x0000, which latches the snapshot.
  - RD_SL: read addr4.
  - RD_SH: read addr5; capture avm_readdata into snapshot[15:0].
  - SNAP_CAP: no access; capture avm_readdata into snapshot[31:16]; pulse snapshot_valid; go to RUN.
  - A stop or irq arriving mid-sequence waits until RUN. An irq that stays asserted is serviced afterwards.
- A stop pulse outside RUN is dropped.
- reset_n asserted mid-sequence aborts immediately to reset values. A partially written timer state is not repaired.

Test Plan:
- Reset, then start with period=0x0001_86A0, continuous=1 → 4 writes: (1,0x0008), (2,0x86A0), (3,0x0001), (1,0x0007) on consecutive cycles. busy=1. RUN idles the bus.
- In RUN, pulse timer_irq 3 times, each held until the status write → 3 writes (0,0x0000). tick_count=3. 3 tick_pulses. No double count.
- continuous=0, start, then one irq → control write 0x0005. After the status write: IDLE, busy=0, tick_count=1.
- snap_req in RUN with slave readdata returning 0x1234 then 0xABCD → accesses (w4), (r4), (r5). snapshot=0xABCD1234. One snapshot_valid pulse, 3 cycles after the r4 read.
- snap_req and timer_irq in the same cycle → status write first, then the snapshot sequence. Also: tick_count preset near all-ones wraps to 0 after the next serviced irq.
- stop in RUN → write (1,0x0008), then IDLE. reset_n low during WR_PH → avm outputs idle and busy=0 the same cycle, asynchronously.

Source files
------------

// File: rtl/barcodescanner_timer_sequencer.sv
// Avalon-MM master that programs the interval timer, services its timeouts and
// captures counter snapshots so scan ticks need no CPU involvement.
//
// state     | meaning
// IDLE      | bus idle, waiting for start
// WR_STOP   | write control = stop before reprogramming
// WR_PL     | write period low half
// WR_PH     | write period high half
// WR_CTRL   | write control = start, cont, ito
// RUN       | bus idle, arbitrate irq > stop > snapshot
// WR_STATUS | clear timeout, emit tick
// HALT      | write control = stop, then idle
// WR_SNAP   | write snap_l to latch the counter
// RD_SL     | read snap_l
// RD_SH     | read snap_h, low half of readdata arrives
// SNAP_CAP  | high half of readdata arrives, publish snapshot
module barcodescanner_timer_sequencer #(
  parameter int TICK_W      = 16,
  parameter bit SNAP_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [31:0]       period,
  input  logic              snap_req,
  input  logic              timer_irq,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  output logic              busy,
  output logic              tick_pulse,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snapshot,
  output logic              snapshot_valid
);

  typedef enum logic [3:0] {
    IDLE, WR_STOP, WR_PL, WR_PH, WR_CTRL, RUN,
    WR_STATUS, HALT, WR_SNAP, RD_SL, RD_SH, SNAP_CAP
  } state_t;

  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  state_t      state, state_nxt;
  logic [31:0] period_q;
  logic        cont_q;
  logic        snap_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q       <= '0;
      cont_q         <= 1'b0;
      snap_pend      <= 1'b0;
      tick_count     <= '0;
      snapshot       <= '0;
      snapshot_valid <= 1'b0;
    end else begin
      snapshot_valid <= 1'b0;
      if (state == IDLE && start) begin
        period_q   <= period;
        cont_q     <= continuous;
        tick_count <= '0;
      end
      if (state == WR_STATUS) tick_count <= tick_count + TICK_ONE;
      // entering service wins over a request in the same cycle: it is already covered
      if (state_nxt == WR_SNAP && state != WR_SNAP) snap_pend <= 1'b0;
      else if (SNAP_ENABLE && snap_req && state != IDLE) snap_pend <= 1'b1;
      if (state == RD_SH) snapshot[15:0] <= avm_readdata;
      if (state == SNAP_CAP) begin
        snapshot[31:16] <= avm_readdata;
        snapshot_valid  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    avm_address    = 3'd0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = 16'h0000;
    tick_pulse     = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: if (start) state_nxt = WR_STOP;
      WR_STOP: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd1; avm_writedata = 16'h0008;
        state_nxt = WR_PL;
      end
      WR_PL: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd2; avm_writedata = period_q[15:0];
        state_nxt = WR_PH;
      end
      WR_PH: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd3; avm_writedata = period_q[31:16];
        state_nxt = WR_CTRL;
      end
      WR_CTRL: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd1; avm_writedata = {12'h000, 1'b0, 1'b1, cont_q, 1'b1};
        state_nxt = RUN;
      end
      RUN: begin
        if (timer_irq)                     state_nxt = WR_STATUS;
        else if (stop)                     state_nxt = HALT;
        else if (SNAP_ENABLE && snap_pend) state_nxt = WR_SNAP;
      end
      WR_STATUS: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd0; avm_writedata = 16'h0000;
        tick_pulse = 1'b1;
        state_nxt = cont_q ? RUN : IDLE;
      end
      HALT: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd1; avm_writedata = 16'h0008;
        state_nxt = IDLE;
      end
      WR_SNAP: begin
        avm_chipselect = 1'b1; avm_write_n = 1'b0;
        avm_address = 3'd4; avm_writedata = 16'h0000;
        state_nxt = RD_SL;
      end
      RD_SL: begin
        avm_chipselect = 1'b1; avm_address = 3'd4;
        state_nxt = RD_SH;
      end
      RD_SH: begin
        avm_chipselect = 1'b1; avm_address = 3'd5;
        state_nxt = SNAP_CAP;
      end
      SNAP_CAP: state_nxt = RUN;
      default:  state_nxt = IDLE;
    endcase
  end

endmodule
